// File: rtl/mic_period_pkg.sv
// rtl/mic_period_pkg.sv - shared FSM states, constants and sample types for the mic period detector
package mic_period_pkg;

  localparam int SAMPLE_W_DEF = 12;
  localparam int MID_SCALE    = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } fsm_state_t;

  // One extra bit so code - dc never overflows.
  typedef logic signed [SAMPLE_W_DEF:0] centered_t;

endpackage

// File: rtl/mic_dc_tracker.sv
// rtl/mic_dc_tracker.sv - first-order IIR estimate of the microphone DC bias
import mic_period_pkg::*;

module mic_dc_tracker #(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int DC_SHIFT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] code,
  output logic [SAMPLE_W-1:0] dc
);

  // One spare bit keeps acc + code from wrapping before the decay term is removed.
  localparam int ACC_W = SAMPLE_W + DC_SHIFT + 1;

  logic [ACC_W-1:0] acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= ACC_W'(MID_SCALE) << DC_SHIFT;
    end else if (sample_valid) begin
      acc <= acc + ACC_W'(code) - (acc >> DC_SHIFT);
    end
  end

  assign dc = SAMPLE_W'(acc >> DC_SHIFT);

endmodule

// File: rtl/mic_period_detector.sv
// rtl/mic_period_detector.sv - rising-crossing period meter; MIC_PERIOD_DC_FILTER_EN enables DC tracking
import mic_period_pkg::*;

module mic_period_detector #(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int PERIOD_W   = 16,
  parameter int HYST       = 64,
  parameter int MIN_PERIOD = 8,
  parameter int MAX_PERIOD = 4095,
  parameter int DC_SHIFT   = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [15:0]         sample,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic                crossing
);

  localparam centered_t             HYST_POS = centered_t'(HYST);
  localparam centered_t             HYST_NEG = -HYST_POS;
  localparam logic [PERIOD_W-1:0] MIN_CNT  = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_CNT  = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] CNT_SAT  = '1;
  localparam logic [PERIOD_W-1:0] CNT_ONE  = PERIOD_W'(1);

  logic [SAMPLE_W-1:0] code;
  logic [SAMPLE_W-1:0] dc;
  centered_t           centered;
  fsm_state_t          state;
  logic                have_ref;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_inc;
  logic                go_high;
  logic                go_low;
  logic                rise;
  logic                unused_bits;

  assign code        = sample[SAMPLE_W-1:0];
  assign unused_bits = ^{sample[15:SAMPLE_W], DC_SHIFT[0]};

`ifdef MIC_PERIOD_DC_FILTER_EN
  mic_dc_tracker #(
    .SAMPLE_W (SAMPLE_W),
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_tracker (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .code         (code),
    .dc           (dc)
  );
`else
  assign dc = SAMPLE_W'(MID_SCALE);
`endif

  assign centered = centered_t'({1'b0, code}) - centered_t'({1'b0, dc});
  assign go_high  = (centered >= HYST_POS);
  assign go_low   = (centered <= HYST_NEG);
  assign rise     = (state == ST_LOW) && go_high;
  assign cnt_inc  = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      have_ref     <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      crossing     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      crossing     <= 1'b0;
      if (sample_valid) begin
        unique case (state)
          ST_IDLE: begin
            if (go_low)       state <= ST_LOW;
            else if (go_high) state <= ST_HIGH;
          end
          ST_LOW:  if (go_high) state <= ST_HIGH;
          ST_HIGH: if (go_low)  state <= ST_LOW;
          default: state <= ST_IDLE;
        endcase

        // A crossing landing on the timeout sample still counts as a period.
        if (rise) begin
          crossing <= 1'b1;
          if (!have_ref) begin
            have_ref <= 1'b1;
            cnt      <= CNT_ONE;
          end else if (cnt < MIN_CNT) begin
            cnt <= cnt_inc;
          end else begin
            period       <= cnt;
            period_valid <= 1'b1;
            locked       <= 1'b1;
            cnt          <= CNT_ONE;
          end
        end else if (have_ref) begin
          if (cnt == MAX_CNT) begin
            have_ref <= 1'b0;
            locked   <= 1'b0;
            period   <= '0;
            cnt      <= '0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mic_period_detector.sv
// tb/tb_mic_period_detector.sv - scoreboard bench for mic_period_detector
module tb_mic_period_detector;

  localparam int LO  = 1548;
  localparam int HI  = 2548;
  localparam int MID = 2048;

  logic        clock        = 1'b0;
  logic        reset        = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] sample       = 16'h0;
  logic [15:0] period;
  logic        period_valid;
  logic        locked;
  logic        crossing;

  mic_period_detector dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample       (sample),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .crossing     (crossing)
  );

  always #5 clock = ~clock;

  typedef struct {
    int idx;
    int per;
  } exp_t;

  exp_t        sb_q[$];
  int          checks      = 0;
  int          errors      = 0;
  int          g_idx       = -1;
  int          base        = 0;
  int          crossings   = 0;
  int          unlock_idx  = -1;
  bit          lenient     = 1'b0;
  int          lenient_per = 0;
  logic [15:0] prev_period = 16'h0;
  logic        prev_locked = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int v);
    @(negedge clock);
    sample_valid = 1'b1;
    sample       = {4'hA, 12'(v)};
    g_idx++;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clock);
      sample_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    sample_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic start_test();
    base = g_idx + 1;
  endtask

  task automatic expect_period(input int off, input int per);
    exp_t e;
    e.idx = base + off;
    e.per = per;
    sb_q.push_back(e);
  endtask

  task automatic wave(input int lo, input int hi, input int p, input int n0, input int n1);
    for (int n = n0; n < n1; n++) send(((n % p) < (p / 2)) ? lo : hi);
  endtask

  // Monitor: pops the scoreboard on every period_valid and polices idle cycles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset === 1'b0) begin
        if (sample_valid) begin
          if (crossing) crossings++;
          if (prev_locked && !locked) unlock_idx = g_idx;
          if (period_valid) begin
            if (lenient) begin
              check("lenient_period", int'(period), lenient_per);
            end else if (sb_q.size() == 0) begin
              check("unexpected_period_valid", int'(period_valid), 0);
            end else begin
              e = sb_q.pop_front();
              check("period_idx", g_idx, e.idx);
              check("period_value", int'(period), e.per);
              check("locked_on_period", int'(locked), 1);
            end
          end
        end else begin
          check("idle_pulses", int'({period_valid, crossing}), 0);
          check("idle_hold_period", int'(period), int'(prev_period));
          check("idle_hold_locked", int'(locked), int'(prev_locked));
        end
      end
      prev_period = period;
      prev_locked = locked;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int pat[19] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int sine[8] = '{0, 25, 50, 25, 0, -25, -50, -25};

    do_reset();
    check("reset_period", int'(period), 0);
    check("reset_period_valid", int'(period_valid), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_crossing", int'(crossing), 0);

    // 40-sample square, back-to-back samples
    start_test();
    c0 = crossings;
    expect_period(60, 40);
    expect_period(100, 40);
    expect_period(140, 40);
    wave(LO, HI, 40, 0, 180);
    gap(2);
    check("sq40_crossings", crossings - c0, 4);
    check("sq40_locked", int'(locked), 1);
    check("sq40_period", int'(period), 40);
    check("sq40_drain", sb_q.size(), 0);

    // small sine inside the hysteresis band
    do_reset();
    c0 = crossings;
    for (int n = 0; n < 200; n++) send(MID + sine[n % 8]);
    gap(2);
    check("sine_crossings", crossings - c0, 0);
    check("sine_locked", int'(locked), 0);
    check("sine_period", int'(period), 0);

    // 3-sample dip right after a crossing is a glitch that keeps counting
    do_reset();
    start_test();
    c0 = crossings;
    expect_period(60, 40);
    expect_period(100, 40);
    for (int n = 0; n < 120; n++) begin
      if (n >= 61 && n <= 63) send(LO);
      else send(((n % 40) < 20) ? LO : HI);
    end
    gap(2);
    check("spike_crossings", crossings - c0, 4);
    check("spike_period", int'(period), 40);
    check("spike_drain", sb_q.size(), 0);

    // MIN_PERIOD boundary: 7 rejected, then 9 and 8 accepted
    do_reset();
    start_test();
    c0 = crossings;
    expect_period(10, 9);
    expect_period(18, 8);
    for (int n = 0; n < 19; n++) send(pat[n] != 0 ? HI : LO);
    gap(2);
    check("minp_crossings", crossings - c0, 4);
    check("minp_period", int'(period), 8);
    check("minp_drain", sb_q.size(), 0);

    // timeout: lock, then flat input
    do_reset();
    start_test();
    unlock_idx = -1;
    expect_period(60, 40);
    wave(LO, HI, 40, 0, 80);
    for (int n = 80; n < 4180; n++) send(MID);
    gap(2);
    check("timeout_unlock_idx", unlock_idx, base + 60 + 4095);
    check("timeout_locked", int'(locked), 0);
    check("timeout_period", int'(period), 0);
    check("timeout_drain", sb_q.size(), 0);

    // crossing exactly on the MAX_PERIOD sample wins over timeout
    do_reset();
    start_test();
    c0 = crossings;
    expect_period(4096, 4095);
    send(LO);
    send(HI);
    for (int n = 2; n < 4096; n++) send(LO);
    send(HI);
    gap(2);
    check("maxp_crossings", crossings - c0, 2);
    check("maxp_locked", int'(locked), 1);
    check("maxp_period", int'(period), 4095);
    check("maxp_drain", sb_q.size(), 0);

    // reset in the middle of a locked wave
    do_reset();
    start_test();
    expect_period(60, 40);
    wave(LO, HI, 40, 0, 90);
    do_reset();
    check("midrst_period", int'(period), 0);
    check("midrst_period_valid", int'(period_valid), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_crossing", int'(crossing), 0);
    start_test();
    c0 = crossings;
    expect_period(60, 40);
    expect_period(100, 40);
    wave(LO, HI, 40, 0, 140);
    gap(2);
    check("midrst_crossings", crossings - c0, 3);
    check("midrst_drain", sb_q.size(), 0);

    // sparse strobes, one sample every 128 clocks, period 25
    do_reset();
    start_test();
    c0 = crossings;
    expect_period(37, 25);
    expect_period(62, 25);
    expect_period(87, 25);
    for (int n = 0; n < 100; n++) begin
      send(((n % 25) < 12) ? LO : HI);
      gap(127);
    end
    check("slow_crossings", crossings - c0, 4);
    check("slow_locked", int'(locked), 1);
    check("slow_period", int'(period), 25);
    check("slow_drain", sb_q.size(), 0);

`ifdef MIC_PERIOD_DC_FILTER_EN
    // biased input: tracker pulls dc toward 1800
    do_reset();
    lenient     = 1'b1;
    lenient_per = 25;
    wave(1300, 2300, 25, 0, 400);
    gap(2);
    check("bias_locked", int'(locked), 1);
    check("bias_period", int'(period), 25);
    lenient = 1'b0;
`endif

    check("final_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
